// File: rtl/bit_deserializer_if.sv
// Output word stream of bit_deserializer: one-entry valid/ready buffer plus drop pulse.
interface bit_deserializer_if #(parameter int DATA_W = 8) ();
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              overflow;

  modport master (output data_out, output data_valid, output overflow, input data_ready);
  modport slave  (input data_out, input data_valid, input overflow, output data_ready);
endinterface

// File: rtl/bit_deserializer.sv
// Mid-bit sampler, sync-word aligner and word assembler behind the clock-recovery stage.
// Optional feature macro BITDESER_RESYNC_EN: re-align on an off-boundary sync match while in DATA.
//
// state | meaning
// IDLE  | not locked; sync/word progress cleared
// HUNT  | shifting sampled bits, searching for SYNC_WORD
// DATA  | assembling DATA_W-bit words, free-running frame
module bit_deserializer #(
  parameter int                DATA_W    = 8,
  parameter int                SYNC_W    = 16,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 16'hA5C3,
  parameter logic [15:0]       MIN_FREQ  = 16'd4
) (
  input  logic                      clk_200M,
  input  logic                      rst,
  input  logic                      signal,
  input  logic [15:0]               clk_freq,
  input  logic                      clk_locked,
  output logic                      bit_strobe,
  output logic                      bit_value,
  output logic                      frame_sync,
  bit_deserializer_if.master        out_bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, HUNT, DATA} state_t;

  state_t              state_q, state_d;
  logic                s1, s2, s2_d;
  logic [15:0]         ph;
  logic [16:0]         ph_inc;
  logic                edge_det, sample;
  logic [SYNC_W-1:0]   sync_sr, sync_d, sync_shift;
  logic [DATA_W-1:0]   word_sr, word_d, word_shift;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                word_done, handshake;

  assign edge_det  = s2 != s2_d;
  assign ph_inc    = {1'b0, ph} + 17'd1;
  assign sample    = (ph == {1'b0, clk_freq[15:1]}) && (clk_freq >= MIN_FREQ) && clk_locked;
  assign handshake = out_bus.data_valid && out_bus.data_ready;

  always_comb begin
    state_d    = state_q;
    sync_d     = sync_sr;
    word_d     = word_sr;
    cnt_d      = cnt;
    word_done  = 1'b0;
    sync_shift = {sync_sr[SYNC_W-2:0], bit_value};
    word_shift = {word_sr[DATA_W-2:0], bit_value};
    case (state_q)
      IDLE: begin
        sync_d = '0;
        word_d = '0;
        cnt_d  = '0;
        if (clk_locked) state_d = HUNT;
      end
      HUNT: begin
        if (bit_strobe) begin
          sync_d = sync_shift;
          if (sync_shift == SYNC_WORD) begin
            state_d = DATA;
            cnt_d   = '0;
            word_d  = '0;
          end
        end
      end
      DATA: begin
        if (bit_strobe) begin
          if (cnt == LAST_BIT) begin
            word_done = 1'b1;
            cnt_d     = '0;
            word_d    = '0;
          end else begin
            word_d = word_shift;
            cnt_d  = cnt + CNT_W'(1);
          end
`ifdef BITDESER_RESYNC_EN
          sync_d = sync_shift;
          // a match that lands exactly on a word boundary is already aligned
          if (sync_shift == SYNC_WORD && cnt != LAST_BIT) begin
            cnt_d  = '0;
            word_d = '0;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (!clk_locked) begin
      state_d   = IDLE;
      sync_d    = '0;
      word_d    = '0;
      cnt_d     = '0;
      word_done = 1'b0;
    end
  end

  always_ff @(posedge clk_200M) begin
    if (rst) begin
      s1                 <= 1'b0;
      s2                 <= 1'b0;
      s2_d               <= 1'b0;
      ph                 <= '0;
      bit_strobe         <= 1'b0;
      bit_value          <= 1'b0;
      state_q            <= IDLE;
      sync_sr            <= '0;
      word_sr            <= '0;
      cnt                <= '0;
      frame_sync         <= 1'b0;
      out_bus.data_out   <= '0;
      out_bus.data_valid <= 1'b0;
      out_bus.overflow   <= 1'b0;
    end else begin
      s1   <= signal;
      s2   <= s1;
      s2_d <= s2;
      // wrap also covers clk_freq shrinking below the current phase
      if (edge_det || ph_inc >= {1'b0, clk_freq}) ph <= '0;
      else                                      ph <= ph_inc[15:0];
      bit_strobe <= sample;
      bit_value  <= s2;
      state_q    <= state_d;
      sync_sr    <= sync_d;
      word_sr    <= word_d;
      cnt        <= cnt_d;
      frame_sync <= (state_d == DATA);
      out_bus.overflow <= 1'b0;
      if (word_done) begin
        if (!out_bus.data_valid || handshake) begin
          out_bus.data_out   <= word_shift;
          out_bus.data_valid <= 1'b1;
        end else begin
          out_bus.overflow <= 1'b1;
        end
      end else if (handshake) begin
        out_bus.data_valid <= 1'b0;
      end
    end
  end

endmodule
